mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the north-bridge memory bus. It accepts single-beat read/write requests from the bridge's memory interface and drives `busy` for the whole access. It services each request against an internal word array with a configurable access latency, then returns read data or a write acknowledge.

## Interface
- `ADDR_W`, default 8: address width; array depth is 2**ADDR_W words.
- `DATA_W`, default 8: data word width.
- `WAIT_CYCLES`, default 2: access latency in cycles; legal range 1..15.
- `clk  in  1`: clock; all logic is rising-edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `read_en  in  1`: read request, sampled only in IDLE.
- `write_en  in  1`: write request, sampled only in IDLE.
- `addr  in  ADDR_W`: request address, captured with the request.
- `wdata  in  DATA_W`: write data, captured with the request.
- `busy  out  1`: high from request acceptance through completion.
- `rdata  out  DATA_W`: read data; holds the last completed read.
- `rvalid  out  1`: one-cycle pulse; `rdata` is valid.
- `wdone  out  1`: one-cycle pulse; write committed.
- `err  out  1`: one-cycle pulse; illegal request (read and write together).

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - `read_en` xor `write_en` high: latch `addr`, `wdata` and op; load counter with WAIT_CYCLES-1; set `busy`=1; go to ACCESS.
  - Both high: pulse `err`, stay in IDLE, no access, `busy` stays 0.
  - Neither high: hold.
- ACCESS:
  - Counter nonzero: decrement.
  - Counter zero, write: store latched `wdata` at latched `addr`, set `wdone`, go to DONE.
  - Counter zero, read: load `rdata` from the array, set `rvalid`, go to DONE.
- DONE: clear `rvalid`/`wdone`, clear `busy`, go to IDLE.
- Requests in ACCESS or DONE are ignored and not queued. The initiator sees `busy` one cycle late, so ignoring these requests is required behaviour, not an error.
- Input changes after acceptance have no effect; only latched values are used.
- Address is used as-is; no wrap logic is needed. The top address 2**ADDR_W-1 is a valid location.
- Counter is 4 bits, unsigned.

## Timing
- Reset (asynchronous, any state): state=IDLE, `busy`=0, `rvalid`=0, `wdone`=0, `err`=0, `rdata`=0, counter=0.
  - An in-flight write is discarded.
  - Array contents are not reset.
- Request sampled at edge E0:
  - `busy` rises after E0.
  - Access completes at edge E(WAIT_CYCLES).
  - `rvalid`/`wdone` are high from E(WAIT_CYCLES) to E(WAIT_CYCLES+1).
  - `busy` falls after E(WAIT_CYCLES+1).
- `busy` is high for WAIT_CYCLES+1 cycles per access.
- The next request is accepted no earlier than E(WAIT_CYCLES+2).
- Write to read: a read accepted after `wdone` returns the new data.
- `err` is high for exactly one cycle after the sampling edge.
- `rdata` changes only on read completion or reset.

## Structure
- Package `mem_bus_pkg`:
  - FSM state enum (IDLE, ACCESS, DONE).
  - Default ADDR_W/DATA_W constants, shared with the bridge-side memory interface.
- Sub-module `mem_array`: single-port synchronous RAM, parameterised by ADDR_W/DATA_W, with write-enable and registered read.
  - The FSM issues the read one cycle early, so that `rdata` is registered in step with `rvalid` at E(WAIT_CYCLES).

## Test plan
- Write then read, WAIT_CYCLES=2: write 0xA5 to 0x10 -> `busy` high 3 cycles, `wdone` pulse at E2. Then read 0x10 -> `rvalid` at E2, `rdata`=0xA5.
- Top address: write 0x3C to 0xFF, read 0xFF -> 0x3C. Location 0x00 is unchanged.
- Request during busy: assert `read_en` to 0x20 while in ACCESS -> ignored, exactly one `rvalid` for the original request.
- Illegal request: `read_en`=`write_en`=1 in IDLE -> `err` pulses one cycle, `busy` stays 0, array unchanged.
- Reset mid-access: assert `rst` during the ACCESS of a write of 0x77 to 0x05 -> all outputs 0 immediately, and a later read of 0x05 returns the pre-write value.
- Latency boundary, WAIT_CYCLES=1: read -> `rvalid` after E1, `busy` high 2 cycles. Back-to-back reads are accepted every 3 cycles.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the north-bridge memory bus: responder FSM states
// and the default address/data widths used on both sides of the bus.
package mem_bus_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with write enable and a registered read
// port. The read register is reset so the responder's rdata starts at zero;
// the storage array itself is never reset.
module mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage: committed on the write-enable edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read: only updates when a read is issued, so it holds the
    // last read word between accesses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one single-beat read or write at a time,
// holds busy for the whole access, waits WAIT_CYCLES cycles (legal 1..15)
// and then pulses rvalid or wdone.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; read+write together pulses err
// ACCESS | latency countdown; access performed when the counter is 0
// DONE   | completion pulse cycle; busy drops on the way back to IDLE
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_en,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              wdone,
    output logic              err
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    mem_state_t        state;
    logic [3:0]        cnt;
    logic              op_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              access_last;
    logic              mem_we;
    logic              mem_re;

    // The array is enabled during the final ACCESS cycle so that the write
    // lands, and the registered read data appears, on the same edge that
    // raises wdone/rvalid.
    assign access_last = (state == ACCESS) && (cnt == 4'd0);
    assign mem_we      = access_last && op_wr;
    assign mem_re      = access_last && !op_wr;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    // Request sequencing with registered status outputs; pulses default low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy    <= 1'b0;
            rvalid  <= 1'b0;
            wdone   <= 1'b0;
            err     <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            wdone  <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_en && write_en) begin
                        err <= 1'b1;
                    end else if (read_en || write_en) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        op_wr   <= write_en;
                        cnt     <= CNT_LOAD;
                        busy    <= 1'b1;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rvalid <= !op_wr;
                        wdone  <= op_wr;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_CYCLES=2 and 1) share the same
// stimulus. A transaction-level model predicts every output each cycle from
// the acceptance edge and the latency; directed scenarios add literal checks.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       read_en;
    logic       write_en;
    logic [7:0] addr;
    logic [7:0] wdata;

    logic       busy_o   [2];
    logic       rvalid_o [2];
    logic       wdone_o  [2];
    logic       err_o    [2];
    logic [7:0] rdata_o  [2];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
        .addr(addr), .wdata(wdata), .busy(busy_o[0]), .rdata(rdata_o[0]),
        .rvalid(rvalid_o[0]), .wdone(wdone_o[0]), .err(err_o[0])
    );

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
        .addr(addr), .wdata(wdata), .busy(busy_o[1]), .rdata(rdata_o[1]),
        .rvalid(rvalid_o[1]), .wdone(wdone_o[1]), .err(err_o[1])
    );

    // Transaction-level model state, one slot per instance.
    int         n = 0;
    bit         m_active [2];
    int         m_t0     [2];
    bit         m_wr     [2];
    logic [7:0] m_a      [2];
    logic [7:0] m_d      [2];
    logic [7:0] m_mem    [2][256];
    bit         m_known  [2][256];
    logic [7:0] m_rdata  [2];
    bit         m_rknown [2];
    bit         e_rv     [2];
    bit         e_wd     [2];
    bit         e_err    [2];

    // Observation counters.
    int         busy_cnt [2];
    int         rv_cnt   [2];
    int         wd_cnt   [2];
    int         err_cnt  [2];
    int         rv_n     [2];
    int         wd_n     [2];
    logic [7:0] last_rd  [2];

    int n_pass  = 0;
    int n_total = 0;
    int e0;

    function automatic int lat(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d at edge %0d: got 0x%0h expected 0x%0h",
                      name, i, n, act, exp);
    endtask

    task automatic model_edge(input int i);
        bit idle;
        e_rv[i]  = 1'b0;
        e_wd[i]  = 1'b0;
        e_err[i] = 1'b0;
        if (!rst) begin
            m_active[i] = 1'b0;
            m_rdata[i]  = 8'h00;
            m_rknown[i] = 1'b1;
            return;
        end
        idle = !m_active[i];
        if (m_active[i]) begin
            if (n == m_t0[i] + lat(i)) begin
                if (m_wr[i]) begin
                    m_mem[i][m_a[i]]   = m_d[i];
                    m_known[i][m_a[i]] = 1'b1;
                    e_wd[i]            = 1'b1;
                end else begin
                    m_rdata[i]  = m_mem[i][m_a[i]];
                    m_rknown[i] = m_known[i][m_a[i]];
                    e_rv[i]     = 1'b1;
                end
            end
            if (n == m_t0[i] + lat(i) + 1) m_active[i] = 1'b0;
        end
        if (idle) begin
            if (read_en && write_en) begin
                e_err[i] = 1'b1;
            end else if (read_en || write_en) begin
                m_active[i] = 1'b1;
                m_t0[i]     = n;
                m_wr[i]     = write_en;
                m_a[i]      = addr;
                m_d[i]      = wdata;
            end
        end
    endtask

    task automatic compare_and_count(input int i);
        chk("busy", i, 32'(busy_o[i]), 32'(m_active[i]));
        chk("rvalid", i, 32'(rvalid_o[i]), 32'(e_rv[i]));
        chk("wdone", i, 32'(wdone_o[i]), 32'(e_wd[i]));
        chk("err", i, 32'(err_o[i]), 32'(e_err[i]));
        if (m_rknown[i]) chk("rdata", i, 32'(rdata_o[i]), 32'(m_rdata[i]));
        if (busy_o[i] === 1'b1) busy_cnt[i]++;
        if (err_o[i] === 1'b1) err_cnt[i]++;
        if (rvalid_o[i] === 1'b1) begin
            rv_cnt[i]++;
            rv_n[i]    = n;
            last_rd[i] = rdata_o[i];
        end
        if (wdone_o[i] === 1'b1) begin
            wd_cnt[i]++;
            wd_n[i] = n;
        end
    endtask

    // One clock: model both instances at the edge, compare 1 time unit later,
    // return at the following falling edge where inputs are driven.
    task automatic cycle();
        @(posedge clk);
        n++;
        model_edge(0);
        model_edge(1);
        #1;
        compare_and_count(0);
        compare_and_count(1);
        @(negedge clk);
    endtask

    task automatic req(input bit r, input bit w, input logic [7:0] a,
                       input logic [7:0] d, input int tail);
        read_en  = r;
        write_en = w;
        addr     = a;
        wdata    = d;
        e0       = n + 1;
        cycle();
        read_en  = 1'b0;
        write_en = 1'b0;
        repeat (tail) cycle();
    endtask

    int b0, b1, c0, c1;

    initial begin
        rst = 1'b0; read_en = 1'b0; write_en = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 2; i++) begin
            busy_cnt[i] = 0; rv_cnt[i] = 0; wd_cnt[i] = 0; err_cnt[i] = 0;
            rv_n[i] = 0; wd_n[i] = 0; last_rd[i] = '0;
            m_active[i] = 0; m_t0[i] = 0; m_wr[i] = 0; m_a[i] = '0; m_d[i] = '0;
            m_rdata[i] = '0; m_rknown[i] = 1; e_rv[i] = 0; e_wd[i] = 0; e_err[i] = 0;
            for (int k = 0; k < 256; k++) begin
                m_mem[i][k] = '0;
                m_known[i][k] = 0;
            end
        end
        repeat (3) cycle();
        chk("reset_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("reset_rdata", 1, 32'(rdata_o[1]), 32'd0);
        rst = 1'b1;
        cycle();

        // Write 0xA5 to 0x10, then read it back.
        b0 = busy_cnt[0]; b1 = busy_cnt[1];
        req(0, 1, 8'h10, 8'hA5, 4);
        chk("wr_busy_cycles", 0, 32'(busy_cnt[0] - b0), 32'd3);
        chk("wr_busy_cycles", 1, 32'(busy_cnt[1] - b1), 32'd2);
        chk("wdone_edge", 0, 32'(wd_n[0] - e0), 32'd2);
        chk("wdone_edge", 1, 32'(wd_n[1] - e0), 32'd1);
        b1 = busy_cnt[1];
        req(1, 0, 8'h10, 8'h00, 4);
        chk("rvalid_edge", 0, 32'(rv_n[0] - e0), 32'd2);
        chk("rvalid_edge", 1, 32'(rv_n[1] - e0), 32'd1);
        chk("rd_busy_cycles", 1, 32'(busy_cnt[1] - b1), 32'd2);
        chk("rd_0x10", 0, 32'(last_rd[0]), 32'hA5);
        chk("rd_0x10", 1, 32'(last_rd[1]), 32'hA5);

        // Top address and location 0.
        req(0, 1, 8'h00, 8'h5A, 4);
        req(0, 1, 8'hFF, 8'h3C, 4);
        req(1, 0, 8'hFF, 8'h00, 4);
        chk("rd_0xff", 0, 32'(last_rd[0]), 32'h3C);
        chk("rd_0xff", 1, 32'(last_rd[1]), 32'h3C);
        req(1, 0, 8'h00, 8'h00, 4);
        chk("rd_0x00", 0, 32'(last_rd[0]), 32'h5A);

        // Request while busy is ignored.
        c0 = rv_cnt[0]; c1 = rv_cnt[1];
        read_en = 1'b1; addr = 8'h10;
        cycle();
        addr = 8'h20;
        cycle();
        read_en = 1'b0;
        repeat (4) cycle();
        chk("ignored_req_rvalids", 0, 32'(rv_cnt[0] - c0), 32'd1);
        chk("ignored_req_rvalids", 1, 32'(rv_cnt[1] - c1), 32'd1);
        chk("ignored_req_rdata", 0, 32'(last_rd[0]), 32'hA5);

        // Illegal request.
        c0 = err_cnt[0]; c1 = err_cnt[1]; b0 = busy_cnt[0]; b1 = busy_cnt[1];
        req(1, 1, 8'h10, 8'hEE, 3);
        chk("err_pulses", 0, 32'(err_cnt[0] - c0), 32'd1);
        chk("err_pulses", 1, 32'(err_cnt[1] - c1), 32'd1);
        chk("err_no_busy", 0, 32'(busy_cnt[0] - b0), 32'd0);
        chk("err_no_busy", 1, 32'(busy_cnt[1] - b1), 32'd0);
        req(1, 0, 8'h10, 8'h00, 4);
        chk("err_array_kept", 0, 32'(last_rd[0]), 32'hA5);

        // Reset in the middle of a write.
        req(0, 1, 8'h05, 8'h11, 4);
        read_en = 1'b0; write_en = 1'b1; addr = 8'h05; wdata = 8'h77;
        cycle();
        write_en = 1'b0;
        chk("pre_reset_busy", 0, 32'(busy_o[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_reset_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("async_reset_busy", 1, 32'(busy_o[1]), 32'd0);
        chk("async_reset_rdata", 0, 32'(rdata_o[0]), 32'd0);
        @(negedge clk);
        cycle();
        rst = 1'b1;
        cycle();
        req(1, 0, 8'h05, 8'h00, 4);
        chk("rd_after_reset", 0, 32'(last_rd[0]), 32'h11);
        chk("rd_after_reset", 1, 32'(last_rd[1]), 32'h11);

        // Back-to-back reads held continuously.
        c1 = rv_cnt[1]; b1 = busy_cnt[1];
        read_en = 1'b1; addr = 8'h10; e0 = n + 1;
        repeat (9) cycle();
        read_en = 1'b0;
        chk("b2b_rvalids", 1, 32'(rv_cnt[1] - c1), 32'd3);
        chk("b2b_busy_cycles", 1, 32'(busy_cnt[1] - b1), 32'd6);
        chk("b2b_last_rvalid_edge", 1, 32'(rv_n[1] - e0), 32'd7);
        repeat (6) cycle();

        // Randomised traffic with occasional resets.
        for (int it = 0; it < 1500; it++) begin
            rst      = ($urandom_range(0, 299) != 0);
            read_en  = ($urandom_range(0, 9) < 3);
            write_en = ($urandom_range(0, 9) < 3);
            addr     = {($urandom_range(0, 1) != 0) ? 4'hF : 4'h0, 4'($urandom)};
            wdata    = 8'($urandom);
            cycle();
        end
        rst = 1'b1; read_en = 1'b0; write_en = 1'b0;
        repeat (5) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
